// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR path: addresses, mstatus
// layout, write masks and small decode helpers used by csr_file.
package csr_pkg;

  // Machine-mode CSR addresses
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  // mstatus layout: only MIE and MPIE are stored, MPP reads as machine mode
  localparam int unsigned MSTATUS_MIE_BIT  = 32'd3;
  localparam int unsigned MSTATUS_MPIE_BIT = 32'd7;
  localparam logic [1:0]  MSTATUS_MPP_M    = 2'b11;
  localparam logic [31:0] MSTATUS_FIXED    = {19'h0, MSTATUS_MPP_M, 11'h0};
  localparam logic [31:0] MSTATUS_WMASK    = 32'h0000_0088;

  // mie: only MSIE(3), MTIE(7), MEIE(11) exist
  localparam logic [31:0] MIE_WMASK = 32'h0000_0888;

  // mtvec/mepc are word aligned (direct mode, IALIGN=32)
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  // SYSTEM opcode, shared with the CSR forwarding unit
  localparam logic [6:0] CSR_OPCODE = 7'b1110011;

  // Stored part of mstatus
  typedef struct packed {
    logic mpie;
    logic mie;
  } mstatus_t;

  // Expand the stored mstatus bits into the architectural read value
  function automatic logic [31:0] mstatus_read(input mstatus_t ms);
    logic [31:0] v;
    v = MSTATUS_FIXED;
    v[MSTATUS_MIE_BIT]  = ms.mie;
    v[MSTATUS_MPIE_BIT] = ms.mpie;
    return v;
  endfunction

  // True for addresses whose storage a CSR write can change
  function automatic logic csr_writable(input logic [11:0] addr);
    logic w;
    case (addr)
      CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC,
      CSR_MCAUSE, CSR_MTVAL, CSR_MCYCLE, CSR_MINSTRET,
      CSR_MCYCLEH, CSR_MINSTRETH: w = 1'b1;
      default:                    w = 1'b0;
    endcase
    return w;
  endfunction

  // Value a write leaves behind, as it reads back
  function automatic logic [31:0] csr_write_mask(input logic [11:0] addr,
                                                 input logic [31:0] wdata);
    logic [31:0] v;
    case (addr)
      CSR_MSTATUS:         v = (wdata & MSTATUS_WMASK) | MSTATUS_FIXED;
      CSR_MIE:             v = wdata & MIE_WMASK;
      CSR_MTVEC, CSR_MEPC: v = wdata & ALIGN_MASK;
      default:             v = wdata;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independent low/high half writes.
// A half write replaces that half and blocks the increment for the cycle;
// the increment carries from the low into the high half in one cycle.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] count_o
);

  logic [63:0] count_q;
  logic [63:0] count_d;

  // Next count: half write wins over increment
  always_comb begin
    count_d = count_q;
    if (wr_lo_i) begin
      count_d = {count_q[63:32], wdata_i};
    end else if (wr_hi_i) begin
      count_d = {wdata_i, count_q[31:0]};
    end else if (inc_i) begin
      count_d = count_q + 64'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Counter register with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= 64'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR storage: combinational ID read port with WB bypass,
// WB write port, trap/mret state updates and the cycle/instret counters.
import csr_pkg::*;

module csr_file #(
  parameter logic [31:0] HART_ID     = 32'h0000_0000,
  parameter logic [31:0] MISA_VALUE  = 32'h4000_0100,
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] csr_addr_in_id,
  output logic [31:0] csr_rdata_out,
  output logic        csr_illegal_out,
  input  logic        wr_csr_n_in_wb,
  input  logic [11:0] csr_addr_in_wb,
  input  logic [31:0] csr_wdata_in_wb,
  input  logic        retire_in_wb,
  input  logic        trap_in_wb,
  input  logic [31:0] trap_pc_in_wb,
  input  logic [31:0] trap_cause_in_wb,
  input  logic [31:0] trap_val_in_wb,
  input  logic        mret_in_wb,
  output logic [31:0] mtvec_out,
  output logic [31:0] mepc_out,
  output logic        mstatus_mie_out
);

  mstatus_t    mstatus_q, mstatus_d;
  logic [31:0] mie_q, mie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;

  logic [63:0] mcycle_s;
  logic [63:0] minstret_s;

  logic        wr_en_s;
  logic        bypass_s;
  logic [31:0] rdata_s;
  logic        illegal_s;

  // A trap in WB squashes the instruction's CSR write
  assign wr_en_s  = ~wr_csr_n_in_wb & ~trap_in_wb;
  assign bypass_s = ~wr_csr_n_in_wb & (csr_addr_in_wb == csr_addr_in_id)
                    & csr_writable(csr_addr_in_id);

  csr_counter64 u_mcycle (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (1'b1),
    .wr_lo_i (wr_en_s & (csr_addr_in_wb == CSR_MCYCLE)),
    .wr_hi_i (wr_en_s & (csr_addr_in_wb == CSR_MCYCLEH)),
    .wdata_i (csr_wdata_in_wb),
    .count_o (mcycle_s)
  );

  csr_counter64 u_minstret (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (retire_in_wb),
    .wr_lo_i (wr_en_s & (csr_addr_in_wb == CSR_MINSTRET)),
    .wr_hi_i (wr_en_s & (csr_addr_in_wb == CSR_MINSTRETH)),
    .wdata_i (csr_wdata_in_wb),
    .count_o (minstret_s)
  );

  // Next state: trap beats mret beats CSR write
  always_comb begin
    mstatus_d  = mstatus_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    if (trap_in_wb) begin
      mepc_d         = trap_pc_in_wb & ALIGN_MASK;
      mcause_d       = trap_cause_in_wb;
      mtval_d        = trap_val_in_wb;
      mstatus_d.mpie = mstatus_q.mie;
      mstatus_d.mie  = 1'b0;
    end else begin
      if (mret_in_wb) begin
        mstatus_d.mie  = mstatus_q.mpie;
        mstatus_d.mpie = 1'b1;
      end else if (wr_en_s && (csr_addr_in_wb == CSR_MSTATUS)) begin
        mstatus_d.mie  = csr_wdata_in_wb[MSTATUS_MIE_BIT];
        mstatus_d.mpie = csr_wdata_in_wb[MSTATUS_MPIE_BIT];
      end else begin
        mstatus_d = mstatus_q;
      end
      if (wr_en_s) begin
        case (csr_addr_in_wb)
          CSR_MIE:      mie_d      = csr_wdata_in_wb & MIE_WMASK;
          CSR_MTVEC:    mtvec_d    = csr_wdata_in_wb & ALIGN_MASK;
          CSR_MSCRATCH: mscratch_d = csr_wdata_in_wb;
          CSR_MEPC:     mepc_d     = csr_wdata_in_wb & ALIGN_MASK;
          CSR_MCAUSE:   mcause_d   = csr_wdata_in_wb;
          CSR_MTVAL:    mtval_d    = csr_wdata_in_wb;
          default:      mie_d      = mie_q;
        endcase
      end else begin
        mie_d = mie_q;
      end
    end
  end

  // CSR storage with synchronous reset discarding same-cycle updates
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mstatus_q  <= '{mpie: 1'b0, mie: 1'b0};
      mie_q      <= 32'h0;
      mtvec_q    <= RESET_MTVEC;
      mscratch_q <= 32'h0;
      mepc_q     <= 32'h0;
      mcause_q   <= 32'h0;
      mtval_q    <= 32'h0;
    end else begin
      mstatus_q  <= mstatus_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
    end
  end

  // Read mux for the ID-stage address; unknown addresses flag illegal
  always_comb begin
    rdata_s   = 32'h0;
    illegal_s = 1'b0;
    case (csr_addr_in_id)
      CSR_MSTATUS:                   rdata_s = mstatus_read(mstatus_q);
      CSR_MISA:                      rdata_s = MISA_VALUE;
      CSR_MIE:                       rdata_s = mie_q;
      CSR_MTVEC:                     rdata_s = mtvec_q;
      CSR_MSCRATCH:                  rdata_s = mscratch_q;
      CSR_MEPC:                      rdata_s = mepc_q;
      CSR_MCAUSE:                    rdata_s = mcause_q;
      CSR_MTVAL:                     rdata_s = mtval_q;
      CSR_MIP:                       rdata_s = 32'h0;
      CSR_MCYCLE, CSR_CYCLE:         rdata_s = mcycle_s[31:0];
      CSR_MCYCLEH, CSR_CYCLEH:       rdata_s = mcycle_s[63:32];
      CSR_MINSTRET, CSR_INSTRET:     rdata_s = minstret_s[31:0];
      CSR_MINSTRETH, CSR_INSTRETH:   rdata_s = minstret_s[63:32];
      CSR_MHARTID:                   rdata_s = HART_ID;
      default: begin
        rdata_s   = 32'h0;
        illegal_s = 1'b1;
      end
    endcase
  end

  // Same-cycle WB write to the address being read is forwarded as it will read back
  assign csr_rdata_out   = bypass_s ? csr_write_mask(csr_addr_in_id, csr_wdata_in_wb)
                                    : rdata_s;
  assign csr_illegal_out = illegal_s;

  assign mtvec_out       = mtvec_q;
  assign mepc_out        = mepc_q;
  assign mstatus_mie_out = mstatus_q.mie;

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: directed scenarios followed by random
// traffic, all checked against a behavioural model of the CSR file.
module tb_csr_file;

  localparam logic [31:0] HART  = 32'h0000_0005;
  localparam logic [31:0] MISA  = 32'h4000_0100;
  localparam logic [31:0] RTVEC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic [11:0] csr_addr_in_id;
  logic [31:0] csr_rdata_out;
  logic        csr_illegal_out;
  logic        wr_csr_n_in_wb;
  logic [11:0] csr_addr_in_wb;
  logic [31:0] csr_wdata_in_wb;
  logic        retire_in_wb;
  logic        trap_in_wb;
  logic [31:0] trap_pc_in_wb;
  logic [31:0] trap_cause_in_wb;
  logic [31:0] trap_val_in_wb;
  logic        mret_in_wb;
  logic [31:0] mtvec_out;
  logic [31:0] mepc_out;
  logic        mstatus_mie_out;

  int n_cmp = 0;
  int n_err = 0;

  // model state
  logic        m_mie, m_mpie;
  logic [31:0] m_mie_reg, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  logic [63:0] m_cycle, m_instret;

  logic [11:0] addr_pool [0:19] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340,
                                    12'h341, 12'h342, 12'h343, 12'h344, 12'hB00,
                                    12'hB02, 12'hB80, 12'hB82, 12'hC00, 12'hC02,
                                    12'hC80, 12'hC82, 12'hF14, 12'h7C0, 12'h000};

  csr_file #(.HART_ID(HART), .MISA_VALUE(MISA), .RESET_MTVEC(RTVEC)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .csr_addr_in_id   (csr_addr_in_id),
    .csr_rdata_out    (csr_rdata_out),
    .csr_illegal_out  (csr_illegal_out),
    .wr_csr_n_in_wb   (wr_csr_n_in_wb),
    .csr_addr_in_wb   (csr_addr_in_wb),
    .csr_wdata_in_wb  (csr_wdata_in_wb),
    .retire_in_wb     (retire_in_wb),
    .trap_in_wb       (trap_in_wb),
    .trap_pc_in_wb    (trap_pc_in_wb),
    .trap_cause_in_wb (trap_cause_in_wb),
    .trap_val_in_wb   (trap_val_in_wb),
    .mret_in_wb       (mret_in_wb),
    .mtvec_out        (mtvec_out),
    .mepc_out         (mepc_out),
    .mstatus_mie_out  (mstatus_mie_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_writable(input logic [11:0] a);
    return (a == 12'h300) || (a == 12'h304) || (a == 12'h305) ||
           (a >= 12'h340 && a <= 12'h343) ||
           (a == 12'hB00) || (a == 12'hB02) || (a == 12'hB80) || (a == 12'hB82);
  endfunction

  function automatic logic [31:0] model_mask(input logic [11:0] a, input logic [31:0] w);
    if (a == 12'h300) return (w & 32'h0000_0088) | 32'h0000_1800;
    if (a == 12'h304) return w & 32'h0000_0888;
    if (a == 12'h305 || a == 12'h341) return {w[31:2], 2'b00};
    return w;
  endfunction

  function automatic logic [32:0] model_read(input logic [11:0] a);
    if (!wr_csr_n_in_wb && csr_addr_in_wb == a && model_writable(a))
      return {1'b0, model_mask(a, csr_wdata_in_wb)};
    case (a)
      12'h300: return {1'b0, 32'h0000_1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3)};
      12'h301: return {1'b0, MISA};
      12'h304: return {1'b0, m_mie_reg};
      12'h305: return {1'b0, m_mtvec};
      12'h340: return {1'b0, m_mscratch};
      12'h341: return {1'b0, m_mepc};
      12'h342: return {1'b0, m_mcause};
      12'h343: return {1'b0, m_mtval};
      12'h344: return {1'b0, 32'h0};
      12'hB00, 12'hC00: return {1'b0, m_cycle[31:0]};
      12'hB80, 12'hC80: return {1'b0, m_cycle[63:32]};
      12'hB02, 12'hC02: return {1'b0, m_instret[31:0]};
      12'hB82, 12'hC82: return {1'b0, m_instret[63:32]};
      12'hF14: return {1'b0, HART};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  task automatic model_update();
    logic        wr;
    logic [63:0] cyc_n, ins_n;
    if (!rst_n) begin
      m_mie = 1'b0; m_mpie = 1'b0; m_mie_reg = 32'h0; m_mtvec = RTVEC;
      m_mscratch = 32'h0; m_mepc = 32'h0; m_mcause = 32'h0; m_mtval = 32'h0;
      m_cycle = 64'h0; m_instret = 64'h0;
    end else begin
      wr    = !wr_csr_n_in_wb && !trap_in_wb;
      cyc_n = m_cycle + 64'd1;
      ins_n = m_instret + (retire_in_wb ? 64'd1 : 64'd0);
      if (wr) begin
        case (csr_addr_in_wb)
          12'h304: m_mie_reg  = csr_wdata_in_wb & 32'h0000_0888;
          12'h305: m_mtvec    = {csr_wdata_in_wb[31:2], 2'b00};
          12'h340: m_mscratch = csr_wdata_in_wb;
          12'h341: m_mepc     = {csr_wdata_in_wb[31:2], 2'b00};
          12'h342: m_mcause   = csr_wdata_in_wb;
          12'h343: m_mtval    = csr_wdata_in_wb;
          12'hB00: cyc_n = {m_cycle[63:32], csr_wdata_in_wb};
          12'hB80: cyc_n = {csr_wdata_in_wb, m_cycle[31:0]};
          12'hB02: ins_n = {m_instret[63:32], csr_wdata_in_wb};
          12'hB82: ins_n = {csr_wdata_in_wb, m_instret[31:0]};
          default: ;
        endcase
      end
      if (trap_in_wb) begin
        m_mepc   = {trap_pc_in_wb[31:2], 2'b00};
        m_mcause = trap_cause_in_wb;
        m_mtval  = trap_val_in_wb;
        m_mpie   = m_mie;
        m_mie    = 1'b0;
      end else if (mret_in_wb) begin
        m_mie  = m_mpie;
        m_mpie = 1'b1;
      end else if (wr && csr_addr_in_wb == 12'h300) begin
        m_mie  = csr_wdata_in_wb[3];
        m_mpie = csr_wdata_in_wb[7];
      end
      m_cycle   = cyc_n;
      m_instret = ins_n;
    end
  endtask

  task automatic compare_all();
    logic [32:0] exp;
    exp = model_read(csr_addr_in_id);
    check_eq($sformatf("rdata@%03h", csr_addr_in_id), csr_rdata_out, exp[31:0]);
    check_eq($sformatf("illegal@%03h", csr_addr_in_id), {31'h0, csr_illegal_out}, {31'h0, exp[32]});
    check_eq("mtvec_out", mtvec_out, m_mtvec);
    check_eq("mepc_out", mepc_out, m_mepc);
    check_eq("mie_out", {31'h0, mstatus_mie_out}, {31'h0, m_mie});
  endtask

  // inputs are set at posedge+1; compare at posedge+3; update model at posedge
  task automatic step();
    #2;
    if (rst_n) compare_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    wr_csr_n_in_wb = 1'b1; trap_in_wb = 1'b0; mret_in_wb = 1'b0; retire_in_wb = 1'b0;
  endtask

  task automatic wb_write(input logic [11:0] a, input logic [31:0] d);
    wr_csr_n_in_wb = 1'b0; csr_addr_in_wb = a; csr_wdata_in_wb = d;
  endtask

  initial begin
    int idx;
    rst_n = 1'b0; csr_addr_in_id = 12'h305; csr_addr_in_wb = 12'h000;
    csr_wdata_in_wb = 32'h0; trap_pc_in_wb = 32'h0; trap_cause_in_wb = 32'h0;
    trap_val_in_wb = 32'h0;
    idle();
    step(); step();
    rst_n = 1'b1;

    // reset values
    #1; check_eq("rst_mtvec", csr_rdata_out, 32'h0);
    csr_addr_in_id = 12'h300; #1; check_eq("rst_mstatus", csr_rdata_out, 32'h0000_1800);
    csr_addr_in_id = 12'hF14; #1; check_eq("rst_hartid", csr_rdata_out, HART);
    check_eq("rst_mie_out", {31'h0, mstatus_mie_out}, 32'h0);
    step();

    // mtvec write with same-cycle bypass
    csr_addr_in_id = 12'h305; wb_write(12'h305, 32'h8000_0107);
    #1; check_eq("byp_mtvec", csr_rdata_out, 32'h8000_0104);
    step();
    idle(); #1; check_eq("mtvec_held", mtvec_out, 32'h8000_0104);
    step();

    // set MIE, trap, mret
    wb_write(12'h300, 32'h0000_0008); step();
    idle(); #1; check_eq("mie_set", {31'h0, mstatus_mie_out}, 32'h1);
    trap_in_wb = 1'b1; trap_pc_in_wb = 32'h0000_0102; trap_cause_in_wb = 32'd11;
    trap_val_in_wb = 32'h0000_00AB; step();
    idle(); #1; check_eq("trap_mepc", mepc_out, 32'h0000_0100);
    csr_addr_in_id = 12'h342; #1; check_eq("trap_mcause", csr_rdata_out, 32'd11);
    csr_addr_in_id = 12'h300; #1; check_eq("trap_mstatus", csr_rdata_out, 32'h0000_1880);
    step();
    mret_in_wb = 1'b1; step();
    idle(); #1; check_eq("mret_mstatus", csr_rdata_out, 32'h0000_1888);
    step();

    // counter carry and write-over-increment
    wb_write(12'hB00, 32'hFFFF_FFFF); step();
    wb_write(12'hB80, 32'h0); step();
    idle(); step(); step();
    csr_addr_in_id = 12'hB00; #1; check_eq("mcycle_lo", csr_rdata_out, 32'h1);
    csr_addr_in_id = 12'hB80; #1; check_eq("mcycle_hi", csr_rdata_out, 32'h1);
    step();
    wb_write(12'hB02, 32'h0000_0050); retire_in_wb = 1'b1; step();
    idle(); csr_addr_in_id = 12'hB02; #1; check_eq("minstret_wr", csr_rdata_out, 32'h0000_0050);
    step();

    // trap squashes write; read-only and unimplemented writes dropped
    wb_write(12'h340, 32'h0000_1234); step();
    csr_addr_in_id = 12'h000; wb_write(12'h340, 32'hDEAD_BEEF); trap_in_wb = 1'b1; step();
    idle(); csr_addr_in_id = 12'h340; #1; check_eq("trap_squash", csr_rdata_out, 32'h0000_1234);
    step();
    wb_write(12'hC00, 32'h0000_0005); step();
    wb_write(12'h7C0, 32'h0000_0007); step();
    idle(); csr_addr_in_id = 12'h7C0; #1;
    check_eq("ill_flag", {31'h0, csr_illegal_out}, 32'h1);
    check_eq("ill_data", csr_rdata_out, 32'h0);
    step();

    // reset beats same-cycle write and trap
    rst_n = 1'b0; wb_write(12'h340, 32'hCAFE_F00D); trap_in_wb = 1'b1; step();
    rst_n = 1'b1; idle(); csr_addr_in_id = 12'h340;
    #1; check_eq("rst2_mscratch", csr_rdata_out, 32'h0);
    check_eq("rst2_mepc", mepc_out, 32'h0);
    check_eq("rst2_mtvec", mtvec_out, RTVEC);
    csr_addr_in_id = 12'h300; #1; check_eq("rst2_mstatus", csr_rdata_out, 32'h0000_1800);
    csr_addr_in_id = 12'hB00; #1; check_eq("rst2_mcycle", csr_rdata_out, 32'h0);
    step();

    // random traffic
    for (int i = 0; i < 800; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      idx = $urandom_range(0, 20);
      csr_addr_in_id = (idx == 20) ? 12'($urandom) : addr_pool[idx];
      idx = $urandom_range(0, 20);
      csr_addr_in_wb = (idx == 20) ? 12'($urandom) : addr_pool[idx];
      if ($urandom_range(0, 3) == 0) csr_addr_in_wb = csr_addr_in_id;
      csr_wdata_in_wb = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3))
                                                    : $urandom;
      wr_csr_n_in_wb   = $urandom_range(0, 1) == 1;
      trap_in_wb       = $urandom_range(0, 15) == 0;
      mret_in_wb       = $urandom_range(0, 7) == 0;
      retire_in_wb     = $urandom_range(0, 1) == 1;
      trap_pc_in_wb    = $urandom;
      trap_cause_in_wb = $urandom;
      trap_val_in_wb   = $urandom;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
- Machine-mode CSR storage for the rv32i core. It is the write/read end of the CSR path whose EX→ID hazard is covered by the CSR forwarding unit.
- Read port: combinational, driven by the ID-stage CSR address.
- Write port: driven by the WB stage, which commits CSR instruction results.
- Also owns the trap/mret state updates and the 64-bit cycle/instret counters. Supplies mtvec/mepc to the fetch redirect logic.

Parameters:
- HART_ID, 32'h0: value returned by mhartid.
- MISA_VALUE, 32'h4000_0100: value returned by misa (RV32I).
- RESET_MTVEC, 32'h0: reset value of mtvec.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- csr_addr_in_id  in  12  ID-stage CSR read address
- csr_rdata_out  out  32  read data (combinational)
- csr_illegal_out  out  1  ID address unimplemented
- wr_csr_n_in_wb  in  1  active-low CSR write enable from WB
- csr_addr_in_wb  in  12  WB write address
- csr_wdata_in_wb  in  32  WB write data (already computed RW/RS/RC result)
- retire_in_wb  in  1  one instruction retires this cycle
- trap_in_wb  in  1  trap taken at WB
- trap_pc_in_wb  in  32  PC of trapping instruction
- trap_cause_in_wb  in  32  mcause value
- trap_val_in_wb  in  32  mtval value
- mret_in_wb  in  1  mret commits at WB
- mtvec_out  out  32  current mtvec
- mepc_out  out  32  current mepc
- mstatus_mie_out  out  1  global interrupt enable

Behaviour:
Implemented addresses:
- Writable: mstatus 300, mie 304, mtvec 305, mscratch 340, mepc 341, mcause 342, mtval 343, mcycle B00, minstret B02, mcycleh B80, minstreth B82.
- Read-only: misa 301, mip 344 (reads 0), cycle C00, instret C02, cycleh C80, instreth C82, mhartid F14.
- Any other address → csr_illegal_out=1, csr_rdata_out=0.
- Writes to read-only or unimplemented addresses are silently dropped. Illegality is raised by ID via csr_illegal_out and by the decoder for address bits [11:10]=11 with a write.

Write masks:
- mstatus: only MIE(3) and MPIE(7) are writable; MPP(12:11) is hardwired 2'b11; all other bits read 0.
- mtvec[1:0] and mepc[1:0] are forced 0 (direct mode, IALIGN=32).
- mie: only bits 3, 7, 11 are writable.

Reset (rst_n=0 at clk edge):
- mtvec=RESET_MTVEC; mstatus reads 32'h0000_1800; all other storage 0.
- Outputs follow storage: mtvec_out=RESET_MTVEC, mepc_out=0, mstatus_mie_out=0.
- Reset mid-operation discards any same-cycle write, trap or mret.

Write timing:
- Writes take effect at the next rising clk when wr_csr_n_in_wb=0.
- Read bypass: if wr_csr_n_in_wb=0, the WB address equals the ID address, and the address is writable, then csr_rdata_out returns the masked write data in the same cycle. No stall is required.

Counters:
- mcycle increments every cycle; minstret increments when retire_in_wb=1.
- Both are 64-bit and wrap from 2^64-1 to 0.
- A write to the low or high half replaces that half only; the written value wins over that cycle's increment for the whole 64-bit counter (no increment that cycle).
- Carry out of the low half is applied to the high half in the same cycle.

Trap (trap_in_wb=1):
- mepc←trap_pc with [1:0]=0; mcause←cause; mtval←trap_val; MPIE←MIE; MIE←0.

mret (mret_in_wb=1):
- MIE←MPIE; MPIE←1.

Priority per cycle: reset > trap > mret > CSR write.
- A trap suppresses a same-cycle CSR write and mret.
- mret plus a write to mstatus: mret wins for mstatus; a write to any other address still commits.
- minstret still counts a retiring instruction when the trap does not retire it (retire_in_wb is owned by WB).

Decomposition:
- Shared package csr_pkg holds:
  - 12-bit address localparams for every CSR above;
  - mstatus bit indices (MIE=3, MPIE=7, MPP=12:11) and the mie writable mask;
  - the csr opcode 7'b1110011, shared with the forwarding unit.
- One sub-module, csr_counter64: 64-bit counter with increment enable plus low/high half write enables. Instantiated twice, for mcycle and minstret.

Test Plan:
- Reset then read 305/300/F14 → 32'h0, 32'h0000_1800, HART_ID. mstatus_mie_out=0.
- Write mtvec=32'h8000_0107 at WB while ID reads 305 in the same cycle → bypass returns 32'h8000_0104. Register holds 32'h8000_0104 next cycle.
- Set MIE via mstatus, then trap with pc=32'h0000_0102, cause=11 → mepc=32'h0000_0100, mcause=11, MIE=0, MPIE=1. Then mret → MIE=1, MPIE=1.
- Write mcycle=32'hFFFF_FFFF, mcycleh=0; after 2 cycles mcycleh=1 and mcycle=1. Write minstret with retire_in_wb=1 → written value held, no increment.
- Trap and a write to mscratch=32'hDEAD_BEEF in the same cycle → mscratch unchanged. Write to 0xC00 or 0x7C0 → no state change; ID read of 0x7C0 gives csr_illegal_out=1, data 0.
- Drive rst_n=0 while wr_csr_n_in_wb=0 and trap_in_wb=1 → all registers return to reset values and no write/trap side effects remain.
